expected_in_accumulator: RTL and testbench

EXPECTED_IN_ACCUMULATOR -- requirements
Module: expected_in_accumulator

---
 rtl/expected_in_accumulator.sv | 157 +++++++++++++++
 tb/tb_expected_in_accumulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/expected_in_accumulator.sv
// Batches up to M expected_in vectors, sums them lane-wise and divides by the batch
// size with a bit-serial restoring divider. Define EXPECTED_IN_ACCUM_ROUND_EN for round-to-nearest.
package expected_in_accumulator_pkg;
  typedef logic [7:0] zero2one_t;
endpackage

module expected_in_accumulator_lane #(
  parameter int W  = 8,
  parameter int CW = 6
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          acc_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [W-1:0]  in_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] bias_i,
  output logic [W-1:0]  quo_o
);
  localparam int SW = W + CW;

  logic [SW-1:0] sum_q;
  logic [SW:0]   div;
  logic [CW:0]   rem_q;
  logic [W-1:0]  quo_q;
  logic          ovf_q;
  logic [CW+1:0] trial, diff;
  logic          take;

  // quo_q starts as the low dividend bits and fills with quotient bits from the right
  assign div   = {1'b0, sum_q} + (SW+1)'(bias_i);
  assign trial = {rem_q, quo_q[W-1]};
  assign diff  = trial - {2'b00, cnt_i};
  assign take  = trial >= {2'b00, cnt_i};
  assign quo_o = ovf_q ? '1 : quo_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (clr_i)      sum_q <= '0;
      else if (acc_i) sum_q <= sum_q + SW'(in_i);
      if (load_i) begin
        rem_q <= div[SW:W];
        quo_q <= div[W-1:0];
        ovf_q <= div[SW:W] >= {1'b0, cnt_i};
      end else if (step_i) begin
        rem_q <= take ? diff[CW:0] : trial[CW:0];
        quo_q <= {quo_q[W-2:0], take};
      end
    end
  end
endmodule

module expected_in_accumulator
  import expected_in_accumulator_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 56
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  zero2one_t [N-1:0]        in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output zero2one_t [N-1:0]        out,
  output logic [$clog2(M+1)-1:0]   count
);
  localparam int W   = $bits(zero2one_t);
  localparam int CW  = $clog2(M+1);
  localparam int SCW = $clog2(W+1);

  typedef enum logic [1:0] {ACCUM, DIVIDE, HOLD} state_t;

  state_t         state_q;
  logic [SCW-1:0] step_q;
  logic [CW-1:0]  count_q, bias;
  logic           in_ready_q, out_valid_q;
  logic           accept, go_div, clr, load, step;
  logic [N-1:0][W-1:0] quo;

  assign accept = in_ready_q & in_valid;
  assign go_div = (accept && count_q == CW'(M-1)) || (flush && (accept || count_q != '0));
  assign clr    = (state_q == HOLD) && out_ready;
  assign load   = (state_q == DIVIDE) && (step_q == '0);
  assign step   = (state_q == DIVIDE) && (step_q != '0);

`ifdef EXPECTED_IN_ACCUM_ROUND_EN
  assign bias = count_q >> 1;
`else
  assign bias = '0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

  // Step 0 loads the dividend, steps 1..W resolve one quotient bit each
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      step_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          count_q    <= count_q + CW'(accept);
          in_ready_q <= !go_div;
          step_q     <= '0;
          if (go_div) state_q <= DIVIDE;
        end
        DIVIDE: begin
          step_q <= step_q + 1'b1;
          if (step_q == SCW'(W)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    expected_in_accumulator_lane #(.W(W), .CW(CW)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .clr_i   (clr),
      .acc_i   (accept),
      .load_i  (load),
      .step_i  (step),
      .in_i    (in[i]),
      .cnt_i   (count_q),
      .bias_i  (bias),
      .quo_o   (quo[i])
    );
    assign out[i] = out_valid_q ? zero2one_t'(quo[i]) : '0;
  end
endmodule

// File: tb/tb_expected_in_accumulator.sv
// Directed and randomized checks of expected_in_accumulator on a small (N=2,M=4)
// and a full-size (N=16,M=56) instance against an arithmetic average model.
module tb_expected_in_accumulator;
  import expected_in_accumulator_pkg::*;

  localparam int W    = $bits(zero2one_t);
  localparam int MAXC = (1 << W) - 1;
  localparam int LAT  = W + 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic            a_in_valid = 0, a_flush = 0, a_out_ready = 0;
  logic            a_in_ready, a_out_valid;
  zero2one_t [1:0] a_in = '0;
  zero2one_t [1:0] a_out;
  logic [2:0]      a_count;

  logic             b_in_valid = 0, b_flush = 0, b_out_ready = 0;
  logic             b_in_ready, b_out_valid;
  zero2one_t [15:0] b_in = '0;
  zero2one_t [15:0] b_out;
  logic [5:0]       b_count;

  expected_in_accumulator #(.N(2), .M(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in(a_in), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out(a_out), .count(a_count));

  expected_in_accumulator #(.N(16), .M(56)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in(b_in), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out(b_out), .count(b_count));

  int nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int avg(input int s, input int c);
    int q;
`ifdef EXPECTED_IN_ACCUM_ROUND_EN
    q = (s + c / 2) / c;
    if (q > MAXC) q = MAXC;
`else
    q = s / c;
`endif
    return q;
  endfunction

  task automatic a_beat(input logic v, input int l0, input int l1, input logic fl);
    a_in_valid = v; a_in[0] = zero2one_t'(l0); a_in[1] = zero2one_t'(l1); a_flush = fl;
    @(posedge clock); #1;
    a_in_valid = 0; a_flush = 0;
  endtask

  task automatic a_wait(output int edges);
    edges = 0;
    while (!a_out_valid && edges < 40) begin
      @(posedge clock); #1; edges++;
    end
  endtask

  task automatic a_ack();
    a_out_ready = 1;
    @(posedge clock); #1;
    a_out_ready = 0;
  endtask

  int s0, s1, e0, e1, cnt, len, lat, v0, v1;
  int bs[16];

  initial begin
    // reset state
    #2;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_out", a_out, 0);
    #10 reset_n = 1;
    @(posedge clock); #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // four beats fill the batch
    a_beat(1, 10, 0, 0); a_beat(1, 20, 0, 0); a_beat(1, 30, 0, 0);
    chk("cnt3", a_count, 3);
    a_beat(1, 42, 4, 0);
    chk("div_in_ready", a_in_ready, 0);
    a_wait(lat);
    chk("lat_full", lat, LAT);
    e0 = avg(102, 4); e1 = avg(4, 4);
    chk("full_l0", a_out[0], e0);
    chk("full_l1", a_out[1], e1);
    chk("full_cnt", a_count, 4);

    // long stall in HOLD with inputs toggling
    for (int k = 0; k < 10; k++) begin
      a_beat(1, $urandom_range(0, MAXC), $urandom_range(0, MAXC), 1);
      chk("hold_l0", a_out[0], e0);
      chk("hold_l1", a_out[1], e1);
      chk("hold_in_ready", a_in_ready, 0);
      chk("hold_cnt", a_count, 4);
    end
    a_ack();
    chk("ack_out_valid", a_out_valid, 0);
    chk("ack_cnt", a_count, 0);
    chk("ack_out", a_out, 0);
    chk("ack_in_ready", a_in_ready, 1);

    // two beats then a separate flush edge
    a_beat(1, 100, 0, 0); a_beat(1, 51, 3, 0);
    a_beat(0, 0, 0, 1);
    chk("flush_in_ready", a_in_ready, 0);
    a_wait(lat);
    chk("lat_flush", lat, LAT);
    chk("flush_cnt", a_count, 2);
    chk("flush_l0", a_out[0], avg(151, 2));
    chk("flush_l1", a_out[1], avg(3, 2));
    a_ack();

    // flush on an empty batch is ignored
    a_beat(0, 0, 0, 1);
    chk("empty_flush_ready", a_in_ready, 1);
    repeat (12) begin @(posedge clock); #1; end
    chk("empty_flush_nvalid", a_out_valid, 0);
    chk("empty_flush_cnt", a_count, 0);

    // flush together with the first beat
    a_beat(1, 7, 200, 1);
    a_wait(lat);
    chk("lat_single", lat, LAT);
    chk("single_cnt", a_count, 1);
    chk("single_l0", a_out[0], 7);
    chk("single_l1", a_out[1], 200);
    a_ack();

    // async reset in the middle of a division
    a_beat(1, 90, 91, 0); a_beat(1, 92, 93, 1);
    repeat (3) @(posedge clock);
    #3 reset_n = 0;
    #1;
    chk("mid_rst_ready", a_in_ready, 0);
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_cnt", a_count, 0);
    chk("mid_rst_out", a_out, 0);
    #3 reset_n = 1;
    @(posedge clock); #1;
    chk("mid_rst_rel_ready", a_in_ready, 1);
    repeat (4) a_beat(1, MAXC, MAXC, 0);
    a_wait(lat);
    chk("max_lat", lat, LAT);
    chk("max_l0", a_out[0], MAXC);
    chk("max_l1", a_out[1], MAXC);
    a_ack();

    // random batches, including idle gaps and both flush styles
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(1, 4); s0 = 0; s1 = 0; cnt = 0;
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0) a_beat(0, 0, 0, 0);
        v0 = $urandom_range(0, MAXC); v1 = $urandom_range(0, MAXC);
        s0 += v0; s1 += v1; cnt++;
        a_beat(1, v0, v1, (k == len - 1 && len < 4 && b[0]) ? 1'b1 : 1'b0);
      end
      if (len < 4 && !b[0]) a_beat(0, 0, 0, 1);
      a_wait(lat);
      chk("rnd_lat", lat, LAT);
      chk("rnd_cnt", a_count, cnt);
      chk("rnd_l0", a_out[0], avg(s0, cnt));
      chk("rnd_l1", a_out[1], avg(s1, cnt));
      a_ack();
    end

    // full-size instance: 56 maximum codes, then 56 random beats
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) bs[i] = 0;
      for (int k = 0; k < 56; k++) begin
        for (int i = 0; i < 16; i++) begin
          v0 = (pass == 0) ? MAXC : int'($urandom_range(0, MAXC));
          b_in[i] = zero2one_t'(v0); bs[i] += v0;
        end
        b_in_valid = 1;
        @(posedge clock); #1;
      end
      b_in_valid = 0;
      lat = 0;
      while (!b_out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
      chk("b_lat", lat, LAT);
      chk("b_cnt", b_count, 56);
      for (int i = 0; i < 16; i++) chk("b_lane", b_out[i], avg(bs[i], 56));
      b_out_ready = 1;
      @(posedge clock); #1;
      b_out_ready = 0;
      chk("b_ack_cnt", b_count, 0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
